// File: rtl/dspi_pkg.sv
// Shared encodings for the DSPI forward/backward interfaces: backward
// instruction commands, forward Type field values and control-packet opcodes.
package dspi_pkg;

  localparam logic [1:0] INSTRUCTION_CMD_IDLE    = 2'd0;
  localparam logic [1:0] INSTRUCTION_CMD_REQUEST = 2'd1;
  localparam logic [1:0] INSTRUCTION_CMD_REWIND  = 2'd2;
  localparam logic [1:0] INSTRUCTION_CMD_RESET   = 2'd3;

  localparam logic [1:0] TYPE_IDLE = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;

  localparam logic [7:0] CTRL_OPCODE_NOP    = 8'h00;
  localparam logic [7:0] CTRL_OPCODE_FLUSH  = 8'h01;
  localparam logic [7:0] CTRL_OPCODE_CONFIG = 8'h02;
  localparam logic [7:0] CTRL_OPCODE_STATUS = 8'h03;

endpackage

// File: rtl/stream_replay_ram.sv
// Replay buffer storage: one synchronous write port and one asynchronous
// read port, so a beat can leave the buffer the cycle after it was written.
module stream_replay_ram #(
  parameter int WIDTH      = 550,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [WIDTH-1:0]      rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a producer beat; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/stream_replay_source.sv
// Packet-buffered stream source feeding a DSPI processing element. Beats are
// held in a replay buffer until their packet's Last beat has been emitted,
// leave only against REQUEST credit, and can be replayed with REWIND.
module stream_replay_source
  import dspi_pkg::*;
#(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int STREAM_ID_WIDTH             = $clog2(STREAM_ID_NUM),
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHUNK_ID_WIDTH              = $clog2(CHUNK_ID_NUM),
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int CHANNEL_ID_WIDTH            = $clog2(CHANNEL_ID_NUM),
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int DEPTH                       = 16,
  parameter int PTR_WIDTH                   = $clog2(DEPTH) + 1,
  parameter int CREDIT_WIDTH                = 17
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [STREAM_ID_WIDTH-1:0]             cfg_StreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            cfg_ChannelID,
  input  logic                                   wr_Valid,
  output logic                                   wr_Ready,
  input  logic [DATA_WIDTH-1:0]                  wr_Data,
  input  logic                                   wr_Last,
  input  logic [CHUNK_ID_WIDTH-1:0]              wr_ChunkID,
  input  logic [STATE_WIDTH-1:0]                 wr_State,
  output logic [DATA_WIDTH-1:0]                  Front_Data,
  output logic [1:0]                             Front_Type,
  output logic                                   Front_Last,
  output logic [STREAM_ID_WIDTH-1:0]             Front_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]              Front_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0]            Front_ChannelID,
  output logic [STATE_WIDTH-1:0]                 Front_State,
  input  logic [INSTRUCTION_WIDTH-1:0]           Front_InstructionType,
  input  logic [STREAM_ID_WIDTH-1:0]             Front_InstructionStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            Front_InstructionChannelID,
  input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Front_InstructionParameter
);

  localparam int ADDR_WIDTH = PTR_WIDTH - 1;
  localparam int BEAT_WIDTH = DATA_WIDTH + 1 + CHUNK_ID_WIDTH + STATE_WIDTH;
  localparam int SUM_WIDTH  = ((CREDIT_WIDTH > INSTRUCTION_PARAMETER_WIDTH) ?
                               CREDIT_WIDTH : INSTRUCTION_PARAMETER_WIDTH) + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = {CREDIT_WIDTH{1'b1}};

  logic [PTR_WIDTH-1:0]    wrPtr;
  logic [PTR_WIDTH-1:0]    rdPtr;
  logic [PTR_WIDTH-1:0]    mark;
  logic [CREDIT_WIDTH-1:0] credit;

  logic [PTR_WIDTH-1:0]    occupancy;
  logic                    idMatch;
  logic                    doRequest;
  logic                    doRewind;
  logic                    doResetInstr;
  logic                    emit;
  logic                    wrEn;
  logic [SUM_WIDTH-1:0]    creditSum;
  logic [CREDIT_WIDTH-1:0] creditNext;

  logic [BEAT_WIDTH-1:0]     rdBeat;
  logic [DATA_WIDTH-1:0]     rdData;
  logic                      rdLast;
  logic [CHUNK_ID_WIDTH-1:0] rdChunkID;
  logic [STATE_WIDTH-1:0]    rdState;

  assign occupancy = wrPtr - mark;
  assign wr_Ready  = !rst && (occupancy < PTR_WIDTH'(DEPTH));
  assign {rdData, rdLast, rdChunkID, rdState} = rdBeat;

  // Decode the backward instruction and work out emission and next credit.
  always_comb begin
    idMatch      = (Front_InstructionStreamID == cfg_StreamID) &&
                   (Front_InstructionChannelID == cfg_ChannelID);
    doRequest    = idMatch &&
                   (Front_InstructionType == INSTRUCTION_WIDTH'(INSTRUCTION_CMD_REQUEST));
    doRewind     = idMatch &&
                   (Front_InstructionType == INSTRUCTION_WIDTH'(INSTRUCTION_CMD_REWIND));
    doResetInstr = idMatch &&
                   (Front_InstructionType == INSTRUCTION_WIDTH'(INSTRUCTION_CMD_RESET));
    emit         = (credit != '0) && (rdPtr != wrPtr);
    wrEn         = wr_Valid && wr_Ready && !doResetInstr;
    creditSum    = SUM_WIDTH'(credit)
                 + (doRequest ? SUM_WIDTH'(Front_InstructionParameter) : '0)
                 - SUM_WIDTH'(emit);
    creditNext   = (creditSum > SUM_WIDTH'(CREDIT_MAX)) ? CREDIT_MAX
                                                         : creditSum[CREDIT_WIDTH-1:0];
  end

  stream_replay_ram #(
    .WIDTH     (BEAT_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(wrPtr[ADDR_WIDTH-1:0]),
    .wrData({wr_Data, wr_Last, wr_ChunkID, wr_State}),
    .rdAddr(rdPtr[ADDR_WIDTH-1:0]),
    .rdData(rdBeat)
  );

  // Pointer and credit bookkeeping; REWIND overrides the emit-side updates.
  always_ff @(posedge clk) begin
    if (rst || doResetInstr) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      mark   <= '0;
      credit <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (doRewind) begin
        rdPtr  <= mark;
        credit <= '0;
      end else begin
        credit <= creditNext;
        if (emit) begin
          rdPtr <= rdPtr + 1'b1;
          if (rdLast) mark <= rdPtr + 1'b1;
        end
      end
    end
  end

  // Forward output register: load the emitted beat, otherwise go idle and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      Front_Data      <= '0;
      Front_Type      <= TYPE_IDLE;
      Front_Last      <= 1'b0;
      Front_StreamID  <= '0;
      Front_ChunkID   <= '0;
      Front_ChannelID <= '0;
      Front_State     <= '0;
    end else if (doResetInstr) begin
      Front_Type <= TYPE_IDLE;
    end else if (emit) begin
      Front_Data      <= rdData;
      Front_Type      <= TYPE_DATA;
      Front_Last      <= rdLast;
      Front_StreamID  <= cfg_StreamID;
      Front_ChunkID   <= rdChunkID;
      Front_ChannelID <= cfg_ChannelID;
      Front_State     <= rdState;
    end else begin
      Front_Type <= TYPE_IDLE;
    end
  end

endmodule
